// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Blocking, direct-mapped, write-through, no-write-allocate data cache placed
//   directly after the Mem stage. Load hits return data in the same cycle.
//   Load misses refill a whole line, word 0 upward, over a simple req/ack word
//   bus. Stores always go through to the bus and update the line only if it is
//   already cached. Dcache_Stall holds the pipeline during misses and stores.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   Mem_DcacheEN        access valid this cycle
//   Mem_DcacheRd        1 = load, 0 = store
//   Mem_DcacheWidth     00 byte, 01 half, 10/11 word
//   Mem_DcacheAddr      byte address
//   Mem_DcacheSign      1 = sign-extend load result, 0 = zero-extend
//   Mem_DcacheWrData    right-aligned store data
//   Dcache_RdData       extended load result (0 when there is no load hit)
//   Dcache_Stall        hold pipeline; request inputs stay stable while 1
//   Bus_Req/Bus_We      bus request and direction (1 = write)
//   Bus_Addr            word-aligned bus address
//   Bus_WrData          byte-lane positioned store data
//   Bus_ByteEn          store byte lanes
//   Bus_Ack             one-cycle completion pulse
//   Bus_RdData          read data, valid with Bus_Ack
//
// Bus handshake: all Bus_* outputs are registered. A transfer completes on the
// first rising edge where Bus_Req && Bus_Ack; until then Bus_Req, Bus_We,
// Bus_Addr, Bus_WrData and Bus_ByteEn stay stable. Bus_Ack with Bus_Req low
// is ignored.
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Mem_DcacheEN,
    input  logic                  Mem_DcacheRd,
    input  logic [1:0]            Mem_DcacheWidth,
    input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
    input  logic                  Mem_DcacheSign,
    input  logic [DATA_WIDTH-1:0] Mem_DcacheWrData,
    output logic [DATA_WIDTH-1:0] Dcache_RdData,
    output logic                  Dcache_Stall,
    output logic                  Bus_Req,
    output logic                  Bus_We,
    output logic [ADDR_WIDTH-1:0] Bus_Addr,
    output logic [DATA_WIDTH-1:0] Bus_WrData,
    output logic [3:0]            Bus_ByteEn,
    input  logic                  Bus_Ack,
    input  logic [DATA_WIDTH-1:0] Bus_RdData
);

    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int LINE_W  = ADDR_WIDTH - 2 - WORD_W;   // tag + line index
    localparam int TAG_W   = LINE_W - INDEX_W;
    localparam int SLOT_W  = INDEX_W + WORD_W;          // word position in data RAM
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Cache storage
    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tag_ram  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_ram [NUM_LINES*LINE_WORDS];

    // Request address fields
    logic [1:0]        req_off;
    logic [WORD_W-1:0] req_word;
    logic [LINE_W-1:0] req_line;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]  req_tag;
    logic [SLOT_W-1:0] req_slot;
    logic              hit;

    assign req_off   = Mem_DcacheAddr[1:0];
    assign req_word  = Mem_DcacheAddr[2 +: WORD_W];
    assign req_line  = Mem_DcacheAddr[ADDR_WIDTH-1:2+WORD_W];
    assign req_index = req_line[INDEX_W-1:0];
    assign req_tag   = req_line[LINE_W-1:INDEX_W];
    assign req_slot  = {req_index, req_word};
    assign hit       = Mem_DcacheEN && valid[req_index] && (tag_ram[req_index] == req_tag);

    // Refill bookkeeping
    logic [LINE_W-1:0]  fill_line;
    logic [WORD_W-1:0]  fill_count;
    logic [WORD_W-1:0]  fill_count_inc;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic [SLOT_W-1:0]  fill_slot;

    assign fill_count_inc = fill_count + WORD_W'(1);
    assign fill_index     = fill_line[INDEX_W-1:0];
    assign fill_tag       = fill_line[LINE_W-1:INDEX_W];
    assign fill_slot      = {fill_index, fill_count};

    logic bus_fire;
    assign bus_fire = Bus_Req && Bus_Ack;

    // A store stays on the inputs for one more cycle after its bus write
    // completes (the cycle in which the pipeline advances). This flag keeps
    // that cycle from launching the same store a second time.
    logic store_done;

    // FSM control strobes
    logic stall_int;
    logic start_refill;
    logic start_write;
    logic fill_done;
    logic write_done;

    // Store lane placement
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_data;

    always_comb begin
        st_be   = 4'b0000;
        st_data = '0;
        case (Mem_DcacheWidth)
            2'b00: begin
                st_be   = 4'b0001 << req_off;
                st_data = {24'd0, Mem_DcacheWrData[7:0]} << {req_off, 3'b000};
            end
            2'b01: begin
                st_be   = req_off[1] ? 4'b1100 : 4'b0011;
                st_data = req_off[1] ? {Mem_DcacheWrData[15:0], 16'd0}
                                     : {16'd0, Mem_DcacheWrData[15:0]};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = Mem_DcacheWrData;
            end
        endcase
    end

    // Addressed word, its store-merged version, and load extraction
    logic [DATA_WIDTH-1:0] hit_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;

    always_comb begin
        hit_word    = data_ram[req_slot];
        merged_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (st_be[b]) begin
                merged_word[8*b +: 8] = st_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        ld_byte = 8'd0;
        case (req_off)
            2'd0:    ld_byte = hit_word[7:0];
            2'd1:    ld_byte = hit_word[15:8];
            2'd2:    ld_byte = hit_word[23:16];
            default: ld_byte = hit_word[31:24];
        endcase
        ld_half = req_off[1] ? hit_word[31:16] : hit_word[15:0];
        ld_data = '0;
        case (Mem_DcacheWidth)
            2'b00:   ld_data = {{24{Mem_DcacheSign & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{Mem_DcacheSign & ld_half[15]}}, ld_half};
            default: ld_data = hit_word;
        endcase
    end

    // FSM next state and strobes
    always_comb begin
        state_next   = state;
        stall_int    = 1'b0;
        start_refill = 1'b0;
        start_write  = 1'b0;
        fill_done    = 1'b0;
        write_done   = 1'b0;
        case (state)
            IDLE: begin
                if (Mem_DcacheEN) begin
                    if (Mem_DcacheRd) begin
                        if (!hit) begin
                            stall_int    = 1'b1;
                            start_refill = 1'b1;
                            state_next   = REFILL;
                        end
                    end else if (!store_done) begin
                        stall_int   = 1'b1;
                        start_write = 1'b1;
                        state_next  = WRITE;
                    end
                end
            end
            REFILL: begin
                stall_int = 1'b1;
                if (bus_fire && (fill_count == LAST_WORD)) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                stall_int = 1'b1;
                if (bus_fire) begin
                    write_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Dcache_Stall  = stall_int && !rst;
    assign Dcache_RdData = (!rst && (state == IDLE) && Mem_DcacheEN && Mem_DcacheRd && hit)
                           ? ld_data : '0;

    // State, valid bits and bus registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            fill_line  <= '0;
            fill_count <= '0;
            store_done <= 1'b0;
            Bus_Req    <= 1'b0;
            Bus_We     <= 1'b0;
            Bus_Addr   <= '0;
            Bus_WrData <= '0;
            Bus_ByteEn <= 4'b0000;
        end else begin
            state      <= state_next;
            store_done <= write_done;

            if (start_refill) begin
                // The line is invalid until its last word arrives, so an
                // abandoned refill never leaves a half-filled valid line.
                valid[req_index] <= 1'b0;
                fill_line        <= req_line;
                fill_count       <= '0;
                Bus_Req          <= 1'b1;
                Bus_We           <= 1'b0;
                Bus_Addr         <= {req_line, {WORD_W{1'b0}}, 2'b00};
            end

            if (start_write) begin
                Bus_Req    <= 1'b1;
                Bus_We     <= 1'b1;
                Bus_Addr   <= {Mem_DcacheAddr[ADDR_WIDTH-1:2], 2'b00};
                Bus_WrData <= st_data;
                Bus_ByteEn <= st_be;
            end

            if ((state == REFILL) && bus_fire) begin
                fill_count <= fill_count_inc;   // wraps to 0 after the last word
                if (fill_done) begin
                    Bus_Req           <= 1'b0;
                    valid[fill_index] <= 1'b1;
                end else begin
                    Bus_Addr <= {fill_line, fill_count_inc, 2'b00};
                end
            end

            if (write_done) begin
                Bus_Req <= 1'b0;
                Bus_We  <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state == REFILL) && bus_fire) begin
                data_ram[fill_slot] <= Bus_RdData;
            end
            if (start_write && hit) begin
                data_ram[req_slot] <= merged_word;
            end
            if (fill_done) begin
                tag_ram[fill_index] <= fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
//   Self-checking bench for dcache_ctrl. A bus responder models main memory
//   and acks requests after a random delay; a shadow memory tracks what
//   memory should contain from the stores issued. Table-driven accesses plus
//   hand-written sequences for reset during refill and stray bus acks.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rd;
  logic [1:0]  width;
  logic [31:0] addr;
  logic        sign;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  dcache_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LINE_WORDS(4),
    .NUM_LINES (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .Mem_DcacheEN    (en),
    .Mem_DcacheRd    (rd),
    .Mem_DcacheWidth (width),
    .Mem_DcacheAddr  (addr),
    .Mem_DcacheSign  (sign),
    .Mem_DcacheWrData(wdata),
    .Dcache_RdData   (rdata),
    .Dcache_Stall    (stall),
    .Bus_Req         (bus_req),
    .Bus_We          (bus_we),
    .Bus_Addr        (bus_addr),
    .Bus_WrData      (bus_wdata),
    .Bus_ByteEn      (bus_be),
    .Bus_Ack         (bus_ack),
    .Bus_RdData      (bus_rdata)
  );

  // ---------------------------------------------------------------- clock/reset
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- memories
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return pat(a);
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] wd,
                                      input logic s, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (wd)
      2'b00:   return s ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return s ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic shadow_store(input logic [31:0] a, input logic [1:0] wd, input logic [31:0] d);
    logic [31:0] wa;
    logic [31:0] w;
    wa = {a[31:2], 2'b00};
    w  = shadow_rd(wa);
    case (wd)
      2'b00: begin
        case (a[1:0])
          2'd0:    w[7:0]   = d[7:0];
          2'd1:    w[15:8]  = d[7:0];
          2'd2:    w[23:16] = d[7:0];
          default: w[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (a[1]) w[31:16] = d[15:0];
        else      w[15:0]  = d[15:0];
      end
      default: w = d;
    endcase
    shadow[wa] = w;
  endtask

  // ---------------------------------------------------------------- bus responder
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;
  } bus_rec_t;

  bus_rec_t bus_log[$];
  int       inject_cnt  = 0;
  int       inject_done = 0;

  initial begin
    int          wait_cnt;
    logic [31:0] w;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
      end else if (rst) begin
        wait_cnt = 0;
      end else if (bus_req) begin
        if (wait_cnt == 0) begin
          if (bus_we) begin
            w = mem.exists(bus_addr) ? mem[bus_addr] : pat(bus_addr);
            for (int b = 0; b < 4; b++) begin
              if (bus_be[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
            end
            mem[bus_addr] = w;
            bus_rdata = '0;
          end else begin
            bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : pat(bus_addr);
          end
          bus_ack = 1'b1;
          bus_log.push_back('{bus_we, bus_addr, bus_wdata, bus_be, cyc});
          wait_cnt = $urandom_range(0, 2);
        end else begin
          wait_cnt--;
        end
      end else if (inject_cnt != inject_done) begin
        // stray ack with no request outstanding
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        inject_done++;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;    // loads only
    logic [31:0] exp_data;   // load: RdData; store: lane-positioned bus data
    logic [3:0]  exp_be;     // stores only
  } vec_t;

  // One pipeline access: drive, then hold until the stall releases.
  task automatic access(input vec_t v, input string name);
    int          base_n;
    int          n_new;
    int          t;
    int          drop_cyc;
    logic [31:0] mask;
    logic [31:0] line_base;
    bus_rec_t    r;
    base_n = bus_log.size();
    @(negedge clk);
    en    = 1'b1;
    rd    = v.rd;
    width = v.width;
    sign  = v.sign;
    addr  = v.addr;
    wdata = v.wdata;
    if (v.rd) exp_q.push_back(v.exp_data);
    else      shadow_store(v.addr, v.width, v.wdata);
    #1;
    check({name, " stall_first_cycle"}, {31'd0, stall}, (v.rd && v.exp_hit) ? 32'd0 : 32'd1);
    if (v.rd && v.exp_hit) begin
      check({name, " hit_rdata"}, rdata, exp_q.pop_front());
    end else begin
      t = 0;
      while (stall && t < 200) begin
        @(negedge clk);
        #1;
        t++;
      end
      check({name, " stall_released"}, {31'd0, stall}, 32'd0);
      drop_cyc = cyc;
      n_new    = bus_log.size() - base_n;
      if (v.rd) begin
        check({name, " miss_rdata"}, rdata, exp_q.pop_front());
        check({name, " refill_beats"}, n_new, 32'd4);
        line_base = {v.addr[31:4], 4'h0};
        for (int k = 0; k < 4; k++) begin
          if (base_n + k < bus_log.size()) begin
            r = bus_log[base_n + k];
            check({name, " refill_addr"}, r.addr, line_base + 32'(4 * k));
            check({name, " refill_we"}, {31'd0, r.we}, 32'd0);
          end
        end
      end else begin
        check({name, " store_beats"}, n_new, 32'd1);
        if (n_new >= 1) begin
          r = bus_log[base_n];
          mask = {{8{v.exp_be[3]}}, {8{v.exp_be[2]}}, {8{v.exp_be[1]}}, {8{v.exp_be[0]}}};
          check({name, " store_we"}, {31'd0, r.we}, 32'd1);
          check({name, " store_addr"}, r.addr, {v.addr[31:2], 2'b00});
          check({name, " store_be"}, {28'd0, r.be}, {28'd0, v.exp_be});
          check({name, " store_data"}, r.wdata & mask, v.exp_data & mask);
        end
      end
      if (n_new >= 1) begin
        check({name, " stall_release_cycle"}, drop_cyc, bus_log[bus_log.size() - 1].cyc + 1);
      end
    end
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clk);
    en = 1'b0;
    #1;
    check({name, " idle_stall"}, {31'd0, stall}, 32'd0);
    check({name, " idle_rdata"}, rdata, 32'd0);
  endtask

  // ---------------------------------------------------------------- test
  vec_t vecs[22];

  initial begin
    vec_t        v;
    int          base_n;
    int          t;
    logic [31:0] a;
    logic [1:0]  wd;
    logic        s;

    //            rd    width  sign  addr          wdata         hit   exp_data      be
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'h1111_1111, 4'h0};
    vecs[1]  = '{1'b1, 2'b00, 1'b1, 32'h0000_010B, 32'h0,        1'b1, 32'h0000_0033, 4'h0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_010B, 32'h0,        1'b1, 32'h0000_0033, 4'h0};
    vecs[3]  = '{1'b1, 2'b01, 1'b1, 32'h0000_010E, 32'h0,        1'b1, 32'h0000_4444, 4'h0};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'hF0E0_D080, 1'b0, 32'hF0E0_D080, 4'hF};
    vecs[5]  = '{1'b1, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        1'b1, 32'hFFFF_F0E0, 4'h0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        1'b1, 32'h0000_F0E0, 4'h0};
    vecs[7]  = '{1'b1, 2'b00, 1'b1, 32'h0000_0100, 32'h0,        1'b1, 32'hFFFF_FF80, 4'h0};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        1'b1, 32'h0000_00D0, 4'h0};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        1'b1, 32'h0000_00F0, 4'h0};
    vecs[10] = '{1'b1, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        1'b1, 32'hFFFF_FFD0, 4'h0};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0105, 32'h1234_56AB, 1'b0, 32'h0000_AB00, 4'h2};
    vecs[12] = '{1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h0,        1'b1, 32'h2222_AB22, 4'h0};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'hCAFE_BEEF, 1'b0, 32'h0000_BEEF, 4'h3};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_2000, 32'h0,        1'b0, 32'h1234_BEEF, 4'h0};
    vecs[15] = '{1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        1'b1, 32'h0000_1234, 4'h0};
    vecs[16] = '{1'b1, 2'b01, 1'b1, 32'h0000_2000, 32'h0,        1'b1, 32'hFFFF_BEEF, 4'h0};
    vecs[17] = '{1'b0, 2'b01, 1'b0, 32'h0000_2006, 32'h0000_8001, 1'b0, 32'h8001_0000, 4'hC};
    vecs[18] = '{1'b1, 2'b11, 1'b1, 32'h0000_2007, 32'h0,        1'b1, 32'h8001_DFFB, 4'h0};
    vecs[19] = '{1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'h0,        1'b0, 32'h0500_FAFF, 4'h0};
    vecs[20] = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'hF0E0_D080, 4'h0};
    vecs[21] = '{1'b1, 2'b10, 1'b0, 32'h0000_0504, 32'h0,        1'b0, 32'h0504_FAFB, 4'h0};

    mem[32'h100]  = 32'h1111_1111;
    mem[32'h104]  = 32'h2222_2222;
    mem[32'h108]  = 32'h3333_3333;
    mem[32'h10C]  = 32'h4444_4444;
    mem[32'h2000] = 32'h1234_5678;
    shadow = mem;

    // reset with a load presented: outputs must read 0
    rst   = 1'b1;
    en    = 1'b1;
    rd    = 1'b1;
    width = 2'b10;
    sign  = 1'b0;
    addr  = 32'h100;
    wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset bus_req", {31'd0, bus_req}, 32'd0);
    check("reset bus_we", {31'd0, bus_we}, 32'd0);
    check("reset bus_addr", bus_addr, 32'd0);
    check("reset bus_wdata", bus_wdata, 32'd0);
    check("reset bus_be", {28'd0, bus_be}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    idle_cycle("post_reset");

    // table-driven accesses
    for (int i = 0; i < 22; i++) begin
      access(vecs[i], $sformatf("vec%0d", i));
    end
    idle_cycle("after_table");

    // random loads over the cached 0x2000 line, expected from shadow memory
    for (int i = 0; i < 16; i++) begin
      a  = 32'h2000 + 32'($urandom_range(0, 15));
      wd = 2'($urandom_range(0, 3));
      s  = 1'($urandom_range(0, 1));
      v  = '{1'b1, wd, s, a, 32'h0, 1'b1, ext(shadow_rd({a[31:2], 2'b00}), wd, s, a[1:0]), 4'h0};
      access(v, $sformatf("rand%0d", i));
    end

    // stray ack with no request outstanding must be ignored
    idle_cycle("stray_pre");
    base_n = bus_log.size();
    inject_cnt++;
    repeat (3) @(negedge clk);
    #1;
    check("stray bus_req", {31'd0, bus_req}, 32'd0);
    check("stray stall", {31'd0, stall}, 32'd0);
    check("stray no_transfer", bus_log.size() - base_n, 32'd0);
    access('{1'b1, 2'b10, 1'b0, 32'h2004, 32'h0, 1'b1, shadow_rd(32'h2004), 4'h0}, "stray_hit");

    // reset after the 2nd refill ack of a miss to 0x300
    idle_cycle("rst_pre");
    base_n = bus_log.size();
    @(negedge clk);
    en    = 1'b1;
    rd    = 1'b1;
    width = 2'b10;
    sign  = 1'b0;
    addr  = 32'h300;
    t = 0;
    while (bus_log.size() < base_n + 2 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("rst_mid refill_beats_before_reset", bus_log.size() - base_n, 32'd2);
    @(negedge clk);
    check("rst_mid bus_req_before_reset", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_mid stall", {31'd0, stall}, 32'd0);
    check("rst_mid rdata", rdata, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid beats_total", bus_log.size() - base_n, 32'd2);
    access('{1'b1, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0300_FCFF, 4'h0}, "rst_refetch");
    access('{1'b1, 2'b10, 1'b0, 32'h2000, 32'h0, 1'b0, shadow_rd(32'h2000), 4'h0}, "rst_cleared");
    idle_cycle("end");

    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Blocking, direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the Mem stage. Consumes the Mem stage's Dcache request signals (enable, read, width, address, sign) plus store data.
- Returns sign/zero-extended load data to MemWB and raises a pipeline stall during misses and stores.
- Refills lines and writes stores through a simple req/ack word bus to the memory arbiter.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; fixed at 32
- LINE_WORDS, 4, words per line; power of two, minimum 2
- NUM_LINES, 64, number of lines; power of two

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Mem_DcacheEN  in  1  access valid this cycle
- Mem_DcacheRd  in  1  1 = load, 0 = store (valid only with EN)
- Mem_DcacheWidth  in  2  00 byte, 01 half, 10 word, 11 treated as word
- Mem_DcacheAddr  in  ADDR_WIDTH  byte address
- Mem_DcacheSign  in  1  1 = sign-extend load, 0 = zero-extend
- Mem_DcacheWrData  in  DATA_WIDTH  store data, right-aligned
- Dcache_RdData  out  DATA_WIDTH  extended load result
- Dcache_Stall  out  1  hold pipeline; request inputs stay stable while 1
- Bus_Req  out  1  bus request
- Bus_We  out  1  1 = write, 0 = read
- Bus_Addr  out  ADDR_WIDTH  word-aligned bus address
- Bus_WrData  out  DATA_WIDTH  store data, byte-lane positioned
- Bus_ByteEn  out  4  write byte lanes
- Bus_Ack  in  1  one-cycle completion pulse
- Bus_RdData  in  DATA_WIDTH  read data, valid with Bus_Ack

Behaviour:

Reset:
- Synchronous, active-high. Clears all valid bits in one cycle and forces FSM to IDLE.
- Bus_Req = 0, Bus_We = 0, Bus_Addr = 0, Bus_WrData = 0, Bus_ByteEn = 0, refill counter = 0.
- Dcache_RdData and Dcache_Stall are combinational and read 0 while reset is asserted.

Address split:
- offset = addr[1:0]
- word index = next log2(LINE_WORDS) bits
- line index = next log2(NUM_LINES) bits
- tag = remaining upper bits
- Hit = EN && valid[index] && tag match.

Alignment:
- Half accesses ignore addr[0]. Word accesses ignore addr[1:0]. No misalignment trap.

FSM states: IDLE, REFILL, WRITE.

IDLE:
- EN = 0: Stall = 0, RdData = 0.
- Load hit: RdData valid combinationally the same cycle, Stall = 0 (zero-latency hit).
- Load miss:
  - Stall = 1 combinationally.
  - Next state REFILL. Latch line base address; refill counter = 0.
  - Clear valid[index] at entry.
- Store (hit or miss):
  - Stall = 1 combinationally. Next state WRITE.
  - Latch Bus_Addr, byte-lane-shifted data, and ByteEn: byte = 1 << offset; half = 0011 or 1100 by addr[1]; word = 1111.
  - On hit, update the cached bytes at this edge. On miss, no allocation.

REFILL:
- Bus_Req = 1, Bus_We = 0, Bus_Addr = line base + 4 × counter.
- Bus_Req and Bus_Addr are held stable until Bus_Ack.
- On each ack, write Bus_RdData into data[index][counter] and increment counter.
- Ack with counter = LINE_WORDS − 1:
  - Write tag, set valid, drop Bus_Req next cycle, return to IDLE.
  - The stalled load then hits the following cycle, so stall deasserts one cycle after the final ack.
- Refill order is always word 0 upward (no critical-word-first).

WRITE:
- Bus_Req = 1, Bus_We = 1 until Bus_Ack. On ack, return to IDLE.
- Stall deasserts in the cycle after the ack, and the pipeline advances.

Load extraction:
- Select the byte or half by offset.
- Sign = 1: replicate its MSB into the upper bits. Sign = 0: zero-fill.
- Word loads ignore Sign.

Boundary conditions:
- Bus_Ack while Bus_Req = 0: ignored.
- Ack in the same cycle Req first asserts: not possible, since Req is registered.
- rst during REFILL or WRITE: transaction abandoned; Bus_Req = 0 the next cycle; the partially filled line stays invalid.
- Index aliasing (same index, different tag): replaces the line on refill.
- Counter wraps to 0 after refill completes.

Test Plan:
1. Reset, then load word at 0x100. Bus_Ack for 4 reads returns 0x11111111, 0x22222222, 0x33333333, 0x44444444.
   - Required: Bus_Addr sequence 0x100, 0x104, 0x108, 0x10C; Stall = 1 until one cycle after the 4th ack; RdData = 0x11111111.
2. After test 1, lb at 0x10B with Sign = 1, then lbu at 0x10B.
   - Required: zero-latency hit; RdData = 0x00000033 for both.
   - Repeat with line word 0xF0E0D080 at 0x100 (e.g. by refilling with that word first): lh at 0x102, Sign = 1 → 0xFFFFF0E0; lhu → 0x0000F0E0.
3. sb data 0xAB at 0x105 (cached line).
   - Required: Bus_We = 1, Bus_Addr = 0x104, ByteEn = 0010, WrData[15:8] = 0xAB; Stall held until the cycle after ack.
   - Subsequent lw 0x104 hits, returning 0x2222AB22.
4. sh to uncached address 0x2000.
   - Required: a single bus write with ByteEn = 0011; no refill.
   - Subsequent lw 0x2000 misses and refills.
5. Assert rst after the 2nd refill ack of a miss to 0x300.
   - Required: Bus_Req = 0 the next cycle; after reset, lw 0x300 issues a fresh 4-word refill starting at 0x300.
6. Load 0x100 and then 0x100 + LINE_WORDS × NUM_LINES × 4 (same index, different tag).
   - Required: the second access misses and refills; a subsequent load of 0x100 misses again.
